// File: rtl/assert_result_logger_pkg.sv
// Shared types, default widths and helpers for the assertion result logger
// and the checker stage that feeds it.
package assert_log_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TS_W    = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_ALARM_N = 2;

    typedef enum logic [0:0] {
        ST_OK    = 1'b0,
        ST_ALARM = 1'b1
    } alarm_state_e;

    // Counters of any width up to 32 bits pass through this, clamped at max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/assert_result_logger_if.sv
// Check-result input and failure-record readout port of the result logger.
interface assert_result_logger_if
    import assert_log_pkg::*;
#(
    parameter int TS_W = DEF_TS_W
) ();

    logic            chk_vld;
    logic            chk_pass;
    logic            rec_valid;
    logic            rec_ready;
    logic [TS_W-1:0] rec_ts;

    modport master (
        output chk_vld, chk_pass, rec_ready,
        input  rec_valid, rec_ts
    );

    modport slave (
        input  chk_vld, chk_pass, rec_ready,
        output rec_valid, rec_ts
    );

endinterface

// File: rtl/assert_result_logger_fifo.sv
// Synchronous failure-record FIFO with registered head/valid outputs; a push
// into a full FIFO is accepted when a pop happens on the same edge.
module result_fifo
    import assert_log_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_TS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             drop,
    output logic             out_valid,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;

    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             accept_s;
    logic [AW-1:0]    rd_nx_s;
    logic [CW-1:0]    cnt_nx_s;
    logic [WIDTH-1:0] head_nx_s;

    // Next occupancy and next head; a fresh push becomes head when it lands in the next read slot.
    always_comb begin
        full_s    = (cnt_r == CNT_FULL);
        empty_s   = (cnt_r == {CW{1'b0}});
        pop_s     = pop && !empty_s;
        accept_s  = push && (!full_s || pop_s);
        drop      = push && !accept_s;
        rd_nx_s   = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        cnt_nx_s  = cnt_r;
        head_nx_s = mem_r[rd_nx_s];
        if (accept_s && !pop_s) begin
            cnt_nx_s = cnt_r + CW'(1'b1);
        end else if (!accept_s && pop_s) begin
            cnt_nx_s = cnt_r - CW'(1'b1);
        end else begin
            cnt_nx_s = cnt_r;
        end
        if (accept_s && (wr_ptr_r == rd_nx_s)) begin
            head_nx_s = push_data;
        end else begin
            head_nx_s = mem_r[rd_nx_s];
        end
    end

    // Storage, pointers and registered head/valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            out_valid <= 1'b0;
            head      <= {WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r  <= rd_nx_s;
            cnt_r     <= cnt_nx_s;
            out_valid <= (cnt_nx_s != {CW{1'b0}});
            head      <= head_nx_s;
        end
    end

endmodule

// File: rtl/assert_result_logger.sv
// Per-cycle assertion outcome logger: saturating pass/fail/drop counters,
// free-running cycle stamp, failure-record FIFO and consecutive-failure alarm.
module assert_result_logger
    import assert_log_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TS_W    = DEF_TS_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ALARM_N = DEF_ALARM_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_alarm,
    assert_result_logger_if.slave  bus,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   ovf,
    output logic                   alarm
);

    localparam int RUN_W = $clog2(ALARM_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ALARM_N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]  cyc_r;
    logic [RUN_W-1:0] run_r;
    alarm_state_e     state_r;

    logic sample_pass_s;
    logic sample_fail_s;
    logic pop_s;
    logic drop_s;

    assign sample_pass_s = bus.chk_vld && bus.chk_pass;
    assign sample_fail_s = bus.chk_vld && !bus.chk_pass;
    assign pop_s         = bus.rec_valid && bus.rec_ready;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sample_fail_s),
        .push_data (cyc_r),
        .pop       (pop_s),
        .drop      (drop_s),
        .out_valid (bus.rec_valid),
        .head      (bus.rec_ts)
    );

    // Cycle stamp and saturating result counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_r    <= {TS_W{1'b0}};
            pass_cnt <= {CNT_W{1'b0}};
            fail_cnt <= {CNT_W{1'b0}};
            drop_cnt <= {CNT_W{1'b0}};
            ovf      <= 1'b0;
        end else begin
            cyc_r <= cyc_r + TS_W'(1'b1);
            if (sample_pass_s) begin
                pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), 32'(CNT_MAX)));
            end
            if (sample_fail_s) begin
                fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), 32'(CNT_MAX)));
            end
            if (drop_s) begin
                drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), 32'(CNT_MAX)));
                ovf      <= 1'b1;
            end
        end
    end

    // Alarm FSM; a clear wins over a same-cycle fail, which still seeds the next run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_OK;
            run_r   <= {RUN_W{1'b0}};
            alarm   <= 1'b0;
        end else if (clr_alarm) begin
            state_r <= ST_OK;
            run_r   <= sample_fail_s ? RUN_W'(1'b1) : {RUN_W{1'b0}};
            alarm   <= 1'b0;
        end else begin
            case (state_r)
                ST_OK: begin
                    if (run_r >= RUN_MAX) begin
                        state_r <= ST_ALARM;
                        alarm   <= 1'b1;
                    end else if (sample_fail_s) begin
                        run_r <= run_r + RUN_W'(1'b1);
                        if ((run_r + RUN_W'(1'b1)) >= RUN_MAX) begin
                            state_r <= ST_ALARM;
                            alarm   <= 1'b1;
                        end
                    end else if (sample_pass_s) begin
                        run_r <= {RUN_W{1'b0}};
                    end
                end
                ST_ALARM: begin
                    alarm <= 1'b1;
                end
                default: begin
                    state_r <= ST_OK;
                    run_r   <= {RUN_W{1'b0}};
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule
